// File: rtl/conflict_free_memory_unmap_pkg.sv
// conflict_free_memory_unmap_pkg: shared lane geometry and the bank-map inverse.
package conflict_free_memory_unmap_pkg;

    localparam int LANES      = 8;
    localparam int OLD_ADDR_W = 10;
    localparam int NEW_ADDR_W = 7;
    localparam int BANK_W     = 3;

    // Forward map stores zone = ^old[9:2]; old[2] is recovered by stripping the parity of old[9:3].
    function automatic logic [OLD_ADDR_W-1:0] addr_unmap(
        input logic [BANK_W-1:0]     bank,
        input logic [NEW_ADDR_W-1:0] new_addr
    );
        return {new_addr, bank[2] ^ (^new_addr), bank[1:0]};
    endfunction

endpackage

// File: rtl/conflict_free_memory_unmap_skid_buffer.sv
// skid_buffer: output register plus one-entry skid; in_ready comes straight from a flop.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            // Output slot frees up: skid has priority, and in_ready is low whenever it is full.
            out_valid  <= skid_valid || in_valid;
            out_data   <= skid_valid ? skid_data : (in_valid ? in_data : out_data);
            skid_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/conflict_free_memory_unmap.sv
// conflict_free_memory_unmap: rebuilds linear coefficient addresses from bank/in-bank pairs,
// flags same-beat bank conflicts and counts output beats per frame.
module conflict_free_memory_unmap
    import conflict_free_memory_unmap_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_BEATS = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*BANK_W-1:0]      bank_number_in,
    input  logic [LANES*NEW_ADDR_W-1:0]  new_address_in,
    input  logic [LANES*DATA_W-1:0]      data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OLD_ADDR_W-1:0]  old_address_out,
    output logic [LANES*DATA_W-1:0]      data_out,
    output logic [LANES-1:0]             conflict_lanes,
    output logic                         conflict_sticky,
    input  logic                         clear,
    output logic                         frame_done
);

    localparam int CNT_W = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
    localparam int PAY_W = LANES * (OLD_ADDR_W + DATA_W + 1);

    logic [LANES*OLD_ADDR_W-1:0] old_addr;
    logic [LANES-1:0]            conflict;
    logic [CNT_W-1:0]            beat_cnt;
    logic                        in_fire;
    logic                        out_fire;
    logic                        last_beat;

    always_comb begin
        old_addr = '0;
        conflict = '0;
        for (int i = 0; i < LANES; i++) begin
            old_addr[OLD_ADDR_W*i +: OLD_ADDR_W] = addr_unmap(bank_number_in[BANK_W*i +: BANK_W],
                                                              new_address_in[NEW_ADDR_W*i +: NEW_ADDR_W]);
            for (int j = 0; j < i; j++)
                conflict[i] = conflict[i] | (bank_number_in[BANK_W*i +: BANK_W] == bank_number_in[BANK_W*j +: BANK_W]);
        end
    end

    skid_buffer #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({conflict, data_in, old_addr}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({conflict_lanes, data_out, old_address_out})
    );

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_beat  = beat_cnt == CNT_W'(NUM_BEATS - 1);
    assign frame_done = out_fire && last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_sticky <= 1'b0;
            beat_cnt        <= '0;
        end else begin
            conflict_sticky <= clear ? 1'b0 : (conflict_sticky || (in_fire && |conflict));
            beat_cnt        <= (clear || (out_fire && last_beat)) ? '0 : beat_cnt + CNT_W'(out_fire);
        end
    end

endmodule
